pc_sequencer: RTL

- Parametrised successor to the single-register program counter in the MIPS monocycle datapath.
- Holds the PC and computes next-PC internally. Sources, in priority order: exception vector, EPC return, jump-register, jump, taken branch, sequential step.
- Adds stall, halt/resume, target-alignment fault detection, an EPC/cause pair and a retired-instruction counter.
- Sits between instruction memory addressing and the control/ALU branch-decision logic.

---
 rtl/pc_sequencer.sv | 138 +++++++++++++
 1 files changed

// File: rtl/pc_sequencer.sv
// pc_sequencer: program counter with internal next-PC selection, traps, EPC/cause,
// halt/resume control and a retired-instruction counter.
`default_nettype none

module pc_sequencer #(
    parameter int               WIDTH        = 32,
    parameter logic [WIDTH-1:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [WIDTH-1:0] EXC_VECTOR   = 32'h0000_0080,
    parameter int               STEP         = 4,
    parameter int               CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             halt,
    input  logic             resume,
    input  logic             branch_taken,
    input  logic [15:0]      branch_imm,
    input  logic             jump,
    input  logic [25:0]      jump_target,
    input  logic             jump_reg,
    input  logic [WIDTH-1:0] reg_target,
    input  logic             exception,
    input  logic             eret,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_plus_step,
    output logic [WIDTH-1:0] epc,
    output logic [1:0]       cause,
    output logic             exc_taken,
    output logic             halted,
    output logic [CNT_W-1:0] retired
);

    localparam int               SHIFT      = $clog2(STEP);
    localparam logic [WIDTH-1:0] STEP_W     = WIDTH'(STEP);
    localparam logic [WIDTH-1:0] ALIGN_MASK = WIDTH'(STEP - 1);
    localparam logic [1:0]       CAUSE_EXT  = 2'd1;
    localparam logic [1:0]       CAUSE_MIS  = 2'd2;

    typedef enum logic {
        S_RUN  = 1'b0,
        S_HALT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] epc_q, epc_d;
    logic [1:0]       cause_q, cause_d;
    logic             exc_q, exc_d;
    logic [CNT_W-1:0] ret_q, ret_d;

    logic [WIDTH-1:0] pc_step;
    logic [WIDTH-1:0] br_off;
    logic [WIDTH-1:0] br_tgt;
    logic [WIDTH-1:0] j_tgt;
    logic [WIDTH-1:0] flow_tgt;
    logic             flow_sel;
    logic             flow_mis;

    assign pc_step  = pc_q + STEP_W;
    assign br_off   = {{(WIDTH-16){branch_imm[15]}}, branch_imm} << SHIFT;
    assign br_tgt   = pc_step + br_off;
    assign j_tgt    = {pc_step[WIDTH-1:28], jump_target, 2'b00};
    assign flow_sel = jump_reg | jump | branch_taken;
    assign flow_tgt = jump_reg ? reg_target : (jump ? j_tgt : br_tgt);
    // Only redirected targets can be misaligned; the sequential step never is.
    assign flow_mis = flow_sel && ((flow_tgt & ALIGN_MASK) != '0);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        epc_d   = epc_q;
        cause_d = cause_q;
        exc_d   = 1'b0;
        ret_d   = ret_q;
        case (state_q)
            S_RUN: begin
                if (exception) begin
                    pc_d    = EXC_VECTOR;
                    epc_d   = pc_q;
                    cause_d = CAUSE_EXT;
                    exc_d   = 1'b1;
                end else if (eret) begin
                    pc_d    = epc_q;
                    cause_d = 2'd0;
                end else if (stall) begin
                    pc_d = pc_q;
                end else if (halt) begin
                    state_d = S_HALT;
                end else if (flow_mis) begin
                    pc_d    = EXC_VECTOR;
                    epc_d   = pc_q;
                    cause_d = CAUSE_MIS;
                    exc_d   = 1'b1;
                end else begin
                    pc_d  = flow_sel ? flow_tgt : pc_step;
                    ret_d = ret_q + CNT_W'(1);
                end
            end
            S_HALT: begin
                // The resume cycle itself holds the PC; advancing restarts next cycle.
                if (resume) begin
                    state_d = S_RUN;
                end
            end
            default: state_d = S_RUN;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_RUN;
            pc_q    <= RESET_VECTOR;
            epc_q   <= '0;
            cause_q <= 2'd0;
            exc_q   <= 1'b0;
            ret_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            epc_q   <= epc_d;
            cause_q <= cause_d;
            exc_q   <= exc_d;
            ret_q   <= ret_d;
        end
    end

    assign pc           = pc_q;
    assign pc_plus_step = pc_step;
    assign epc          = epc_q;
    assign cause        = cause_q;
    assign exc_taken    = exc_q;
    assign halted       = (state_q == S_HALT);
    assign retired      = ret_q;

endmodule

`default_nettype wire
